// File: rtl/mem_bist.sv
// Single-port DEPTH x DATA_W RAM with an integrated March X self-test engine.
// In IDLE the array behaves as a plain synchronous RAM with 1-cycle read latency.
// A sampled bist_start runs M0..M3 autonomously. The run reports pass/fail,
// the first failing address and a saturating mismatch count.
module mem_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ERR_W-1:0]  err_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] ONES      = {DATA_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_DONE
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              phase_q, phase_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              cmp_en;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_at;
  logic              finish;

  // Next-state, array access and mismatch bookkeeping for the functional port and March X engine
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    phase_d     = phase_q;
    cmp_vld_d   = cmp_vld_q;
    cmp_addr_d  = cmp_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_wa      = ptr_q;
    mem_wd      = '0;
    rd_en       = 1'b0;
    rd_addr     = ptr_q;
    cmp_en      = 1'b0;
    cmp_exp     = '0;
    cmp_at      = ptr_q;
    finish      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bist_start) begin
          state_d     = ST_M0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_d       = '0;
          fail_addr_d = '0;
          ptr_d       = '0;
        end else if (read) begin
          // A simultaneous write is dropped; the read wins.
          rd_en   = 1'b1;
          rd_addr = addr;
        end else if (write) begin
          mem_we = 1'b1;
          mem_wa = addr;
          mem_wd = data_in;
        end
      end

      ST_M0: begin
        mem_we = 1'b1;
        if (ptr_q == ADDR_LAST) begin
          state_d = ST_M1;
          ptr_d   = '0;
          phase_d = 1'b0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end

      ST_M1: begin
        if (!phase_q) begin
          rd_en   = 1'b1;
          phase_d = 1'b1;
        end else begin
          cmp_en  = 1'b1;
          cmp_exp = '0;
          mem_we  = 1'b1;
          mem_wd  = ONES;
          phase_d = 1'b0;
          if (ptr_q == ADDR_LAST) begin
            state_d = ST_M2;
            ptr_d   = ADDR_LAST;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end

      ST_M2: begin
        if (!phase_q) begin
          rd_en   = 1'b1;
          phase_d = 1'b1;
        end else begin
          cmp_en  = 1'b1;
          cmp_exp = ONES;
          mem_we  = 1'b1;
          mem_wd  = '0;
          phase_d = 1'b0;
          if (ptr_q == '0) begin
            state_d   = ST_M3;
            ptr_d     = '0;
            cmp_vld_d = 1'b0;
          end else begin
            ptr_d = ptr_q - ADDR_W'(1);
          end
        end
      end

      ST_M3: begin
        // Reads are pipelined: each cycle checks the word issued the cycle before.
        if (cmp_vld_q) begin
          cmp_en  = 1'b1;
          cmp_exp = '0;
          cmp_at  = cmp_addr_q;
        end
        if (!phase_q) begin
          rd_en      = 1'b1;
          cmp_addr_d = ptr_q;
          cmp_vld_d  = 1'b1;
          if (ptr_q == ADDR_LAST) begin
            phase_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end else begin
          // Drain cycle: last compare only, then report.
          cmp_vld_d = 1'b0;
          phase_d   = 1'b0;
          finish    = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (cmp_en && (data_out_q != cmp_exp)) begin
      if (err_q == '0) fail_addr_d = cmp_at;
      if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
    end

    if (finish) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == '0);
    end

    data_out_d = rd_en ? mem_q[rd_addr] : data_out_q;
  end

  // Array storage; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      phase_q     <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      phase_q     <= phase_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      err_q       <= err_d;
    end
  end

  assign data_out  = data_out_q;
  assign bist_busy = busy_q;
  assign bist_done = done_q;
  assign bist_pass = pass_q;
  assign fail_addr = fail_addr_q;
  assign err_count = err_q;

endmodule
